iobuf_halfduplex_ctrl: RTL

//  Sequences a single bidirectional tri-state pad (IOBUF-style: I/T into buffer, O back) as a

---
 rtl/iobuf_halfduplex_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/iobuf_halfduplex_ctrl.sv
// Half-duplex sequencer for one bidirectional tri-state pad.
// Arbitrates write/read requesters, shifts WIDTH-bit words MSB first,
// and holds the pad released for a turnaround gap after every transfer.
module iobuf_halfduplex_ctrl #(
  parameter int WIDTH     = 8,
  parameter int TA_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             pad_i,
  output logic             pad_t,
  input  logic             pad_o
);

  // One counter serves both the bit phase and the turnaround phase.
  localparam int CW = $clog2(WIDTH + 16);

  typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] sh, sh_nx;
  logic [WIDTH:0]   sh_ext;
  logic             last_rd, last_rd_nx;
  logic             ack_nx, vld_nx;

  // Next-state, shift and arbitration logic.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    sh_nx      = sh;
    sh_ext     = '0;
    last_rd_nx = last_rd;
    ack_nx     = 1'b0;
    vld_nx     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        // On a tie the requester not served last time wins.
        if (wr_req && (!rd_req || last_rd)) begin
          state_nx   = WRITE;
          sh_nx      = wr_data;
          last_rd_nx = 1'b0;
        end else if (rd_req) begin
          state_nx   = READ;
          sh_nx      = '0;
          last_rd_nx = 1'b1;
        end
      end
      WRITE: begin
        // Extended vector keeps the shift legal for WIDTH == 1.
        sh_ext = {sh, 1'b0};
        sh_nx  = sh_ext[WIDTH-1:0];
        if (cnt == CW'(WIDTH - 1)) begin
          state_nx = TURN;
          cnt_nx   = '0;
          ack_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      READ: begin
        sh_ext = {sh, pad_o};
        sh_nx  = sh_ext[WIDTH-1:0];
        if (cnt == CW'(WIDTH - 1)) begin
          state_nx = TURN;
          cnt_nx   = '0;
          vld_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        if (cnt == CW'(TA_CYCLES - 1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
    endcase
  end

  // State register; pad controls are registered from the next state so no
  // input reaches pad_t/pad_i combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      last_rd  <= 1'b1;
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      busy     <= 1'b0;
      pad_t    <= 1'b1;
      pad_i    <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      sh       <= sh_nx;
      last_rd  <= last_rd_nx;
      wr_ack   <= ack_nx;
      rd_valid <= vld_nx;
      if (vld_nx) rd_data <= sh_nx;
      busy     <= (state_nx != IDLE);
      pad_t    <= (state_nx != WRITE);
      pad_i    <= (state_nx == WRITE) ? sh_nx[WIDTH-1] : 1'b0;
    end
  end

endmodule
